// File: rtl/leastsquares_accum.sv
// leastsquares_accum
// Streaming accumulator for least-squares line fitting. Each accepted
// (x, y) sample adds x, y, x*x and x*y into running sums and bumps a
// saturating sample counter. The frame closes on the sample marked
// s_last. The finished sums are then presented on res_* and held there
// until the consumer takes them with res_valid/res_ready.
//
// Ports:
//   ACLK, ARESET         clock, synchronous active-high reset
//   s_valid/s_ready      sample handshake; s_x, s_y signed samples,
//                        s_last marks the final sample of a frame
//   res_valid/res_ready  result handshake
//   res_n                accepted-sample count (saturates at all-ones)
//   res_sx/sy/sxx/sxy    ACC_W-bit wrapping sums of x, y, x*x, x*y
//   ovf                  sample count saturated during this frame
//   busy                 a frame is in progress (state is not IDLE)
module leastsquares_accum #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16,
  parameter int ACC_W  = 48
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_x,
  input  logic [DATA_W-1:0] s_y,
  input  logic              s_last,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_n,
  output logic [ACC_W-1:0]  res_sx,
  output logic [ACC_W-1:0]  res_sy,
  output logic [ACC_W-1:0]  res_sxx,
  output logic [ACC_W-1:0]  res_sxy,
  output logic              ovf,
  output logic              busy
);

  localparam int PROD_W = 2 * DATA_W;
  localparam int PAD_D  = ACC_W - DATA_W;
  localparam int PAD_P  = ACC_W - PROD_W;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ACC, FLUSH, HOLD} state_t;

  state_t state, state_nxt;

  logic accept;
  logic done;

  logic [PROD_W-1:0] x_wide, y_wide;
  logic [PROD_W-1:0] prod_xx, prod_xy;

  logic              st1_valid;
  logic [ACC_W-1:0]  st1_x, st1_y;
  logic [PROD_W-1:0] st1_xx, st1_xy;

  assign accept = s_valid & s_ready;
  assign done   = res_valid & res_ready;

  // Operands are widened to the product width before multiplying, so the
  // truncated product equals the exact signed product.
  assign x_wide  = {{DATA_W{s_x[DATA_W-1]}}, s_x};
  assign y_wide  = {{DATA_W{s_y[DATA_W-1]}}, s_y};
  assign prod_xx = x_wide * x_wide;
  assign prod_xy = x_wide * y_wide;

  // State register.
  always_ff @(posedge ACLK) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs. FLUSH is the single cycle in which
  // the last sample drains from stage 1 into the accumulators.
  always_comb begin
    state_nxt = state;
    s_ready   = 1'b0;
    res_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        s_ready = 1'b1;
        busy    = 1'b0;
        if (accept) state_nxt = s_last ? FLUSH : ACC;
      end
      ACC: begin
        s_ready = 1'b1;
        if (accept && s_last) state_nxt = FLUSH;
      end
      FLUSH: state_nxt = HOLD;
      HOLD: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage 1 captures the sign-extended samples and their products on the
  // accepting edge; stage 2 folds them into the sums one edge later. The
  // result handshake clears everything for the next frame; no sample can
  // be in flight then because s_ready is low through FLUSH and HOLD.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      st1_valid <= 1'b0;
      st1_x     <= '0;
      st1_y     <= '0;
      st1_xx    <= '0;
      st1_xy    <= '0;
      res_n     <= '0;
      res_sx    <= '0;
      res_sy    <= '0;
      res_sxx   <= '0;
      res_sxy   <= '0;
      ovf       <= 1'b0;
    end else begin
      st1_valid <= accept;
      if (accept) begin
        st1_x  <= {{PAD_D{s_x[DATA_W-1]}}, s_x};
        st1_y  <= {{PAD_D{s_y[DATA_W-1]}}, s_y};
        st1_xx <= prod_xx;
        st1_xy <= prod_xy;
      end
      if (done) begin
        res_n   <= '0;
        res_sx  <= '0;
        res_sy  <= '0;
        res_sxx <= '0;
        res_sxy <= '0;
        ovf     <= 1'b0;
      end else if (st1_valid) begin
        res_sx  <= res_sx  + st1_x;
        res_sy  <= res_sy  + st1_y;
        res_sxx <= res_sxx + {{PAD_P{st1_xx[PROD_W-1]}}, st1_xx};
        res_sxy <= res_sxy + {{PAD_P{st1_xy[PROD_W-1]}}, st1_xy};
        // The counter sticks at all-ones; sums keep going regardless.
        if (res_n == CNT_MAX) ovf   <= 1'b1;
        else                  res_n <= res_n + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_leastsquares_accum.sv
// tb_leastsquares_accum
// Self-checking bench for leastsquares_accum. Two instances share one
// stimulus stream: one with default parameters and one with a 4-bit
// sample counter, so counter saturation is visible in the same frames.
// Expected results come from a plain-arithmetic model over the samples
// of the current frame.
module tb_leastsquares_accum;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 48;

  logic clk = 1'b0;
  logic areset;
  logic s_valid;
  logic [DATA_W-1:0] s_x, s_y;
  logic s_last;
  logic res_ready;

  logic s_ready, res_valid, ovf, busy;
  logic [15:0] res_n;
  logic [ACC_W-1:0] res_sx, res_sy, res_sxx, res_sxy;

  logic s_ready4, res_valid4, ovf4, busy4;
  logic [3:0] res_n4;
  logic [ACC_W-1:0] res_sx4, res_sy4, res_sxx4, res_sxy4;

  int checks = 0;
  int errors = 0;
  bit gaps   = 1'b0;

  int fx[$];
  int fy[$];

  always #5 clk = ~clk;

  leastsquares_accum #(.DATA_W(DATA_W), .CNT_W(16), .ACC_W(ACC_W)) dut (
    .ACLK(clk), .ARESET(areset), .s_valid(s_valid), .s_ready(s_ready),
    .s_x(s_x), .s_y(s_y), .s_last(s_last), .res_valid(res_valid),
    .res_ready(res_ready), .res_n(res_n), .res_sx(res_sx), .res_sy(res_sy),
    .res_sxx(res_sxx), .res_sxy(res_sxy), .ovf(ovf), .busy(busy)
  );

  leastsquares_accum #(.DATA_W(DATA_W), .CNT_W(4), .ACC_W(ACC_W)) dut4 (
    .ACLK(clk), .ARESET(areset), .s_valid(s_valid), .s_ready(s_ready4),
    .s_x(s_x), .s_y(s_y), .s_last(s_last), .res_valid(res_valid4),
    .res_ready(res_ready), .res_n(res_n4), .res_sx(res_sx4), .res_sy(res_sy4),
    .res_sxx(res_sxx4), .res_sxy(res_sxy4), .ovf(ovf4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Outputs of both instances in the idle, between-frames condition.
  task automatic check_idle(input string tag);
    check({tag, "_res_valid"}, 64'(res_valid), 64'(0));
    check({tag, "_busy"},      64'(busy),      64'(0));
    check({tag, "_s_ready"},   64'(s_ready),   64'(1));
    check({tag, "_n"},         64'(res_n),     64'(0));
    check({tag, "_sx"},        64'(res_sx),    64'(0));
    check({tag, "_sy"},        64'(res_sy),    64'(0));
    check({tag, "_sxx"},       64'(res_sxx),   64'(0));
    check({tag, "_sxy"},       64'(res_sxy),   64'(0));
    check({tag, "_ovf"},       64'(ovf),       64'(0));
    check({tag, "_n4"},        64'(res_n4),    64'(0));
    check({tag, "_ovf4"},      64'(ovf4),      64'(0));
    check({tag, "_s_ready4"},  64'(s_ready4),  64'(1));
  endtask

  // Model: plain sums over the frame queue, reduced to ACC_W bits.
  task automatic check_results(input string tag);
    longint sx = 0, sy = 0, sxx = 0, sxy = 0;
    longint cnt;
    logic [ACC_W-1:0] m;
    cnt = fx.size();
    foreach (fx[i]) begin
      sx  += fx[i];
      sy  += fy[i];
      sxx += longint'(fx[i]) * fx[i];
      sxy += longint'(fx[i]) * fy[i];
    end
    check({tag, "_res_valid"}, 64'(res_valid), 64'(1));
    check({tag, "_s_ready"},   64'(s_ready),   64'(0));
    check({tag, "_n"},   64'(res_n), 64'((cnt > 65535) ? 65535 : cnt));
    check({tag, "_ovf"}, 64'(ovf),   64'(cnt > 65535));
    m = ACC_W'(sx);  check({tag, "_sx"},  64'(res_sx),  64'(m));
    m = ACC_W'(sy);  check({tag, "_sy"},  64'(res_sy),  64'(m));
    m = ACC_W'(sxx); check({tag, "_sxx"}, 64'(res_sxx), 64'(m));
    m = ACC_W'(sxy); check({tag, "_sxy"}, 64'(res_sxy), 64'(m));
    check({tag, "_n4"},   64'(res_n4), 64'((cnt > 15) ? 15 : cnt));
    check({tag, "_ovf4"}, 64'(ovf4),   64'(cnt > 15));
    m = ACC_W'(sx);  check({tag, "_sx4"}, 64'(res_sx4), 64'(m));
  endtask

  // Sends the queued samples starting from a negedge; res_ready toggles
  // randomly throughout and must be ignored outside HOLD. Optional idle
  // gaps carry random data that must be ignored.
  task automatic apply_stimulus(input bit do_last);
    foreach (fx[i]) begin
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        s_valid   = 1'b0;
        s_x       = DATA_W'($urandom);
        s_y       = DATA_W'($urandom);
        s_last    = 1'b1;
        res_ready = 1'($urandom_range(0, 1));
        @(posedge clk); @(negedge clk);
      end
      s_valid   = 1'b1;
      s_x       = DATA_W'(fx[i]);
      s_y       = DATA_W'(fy[i]);
      s_last    = do_last && (i == fx.size() - 1);
      res_ready = 1'($urandom_range(0, 1));
      check("accept_s_ready", 64'(s_ready), 64'(1));
      check("accept_res_valid", 64'(res_valid), 64'(0));
      @(posedge clk); @(negedge clk);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // Called at the negedge just after s_last was accepted (FLUSH cycle).
  // Checks result latency, stability under backpressure and the clear on
  // the result handshake.
  task automatic check_output(input string tag, input int hold);
    s_valid   = 1'b1;
    s_x       = DATA_W'($urandom);
    s_y       = DATA_W'($urandom);
    s_last    = 1'b1;
    res_ready = 1'($urandom_range(0, 1));
    check({tag, "_flush_res_valid"}, 64'(res_valid), 64'(0));
    check({tag, "_flush_s_ready"},   64'(s_ready),   64'(0));
    check({tag, "_flush_busy"},      64'(busy),      64'(1));
    @(posedge clk); @(negedge clk);
    res_ready = 1'b0;
    check_results(tag);
    for (int k = 0; k < hold; k++) begin
      s_x = DATA_W'($urandom);
      s_y = DATA_W'($urandom);
      @(posedge clk); @(negedge clk);
      check_results({tag, "_hold"});
    end
    res_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    res_ready = 1'b0;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    check_idle({tag, "_after"});
  endtask

  initial begin
    int len;
    areset = 1'b1; s_valid = 1'b0; s_x = '0; s_y = '0;
    s_last = 1'b0; res_ready = 1'b0;

    @(posedge clk); @(negedge clk);
    check("reset_res_valid", 64'(res_valid), 64'(0));
    check("reset_busy",      64'(busy),      64'(0));
    check("reset_n",         64'(res_n),     64'(0));
    @(posedge clk); @(negedge clk);
    areset = 1'b0;
    check_idle("post_reset");

    $display("[TB] back-to-back frame (1,2),(2,4),(3,6)");
    fx = '{1, 2, 3}; fy = '{2, 4, 6};
    apply_stimulus(1'b1);
    check_output("f3", 0);

    $display("[TB] negative operands");
    fx = '{-3, -1}; fy = '{5, -2};
    apply_stimulus(1'b1);
    check_output("neg", 1);

    $display("[TB] single-sample frame then backpressure");
    fx = '{7}; fy = '{-7};
    apply_stimulus(1'b1);
    check_output("single", 5);
    fx = '{2}; fy = '{3};
    apply_stimulus(1'b1);
    check_output("after_bp", 2);

    $display("[TB] reset mid-frame");
    fx = '{5, 5}; fy = '{5, 5};
    apply_stimulus(1'b0);
    areset = 1'b1;
    @(posedge clk); @(negedge clk);
    areset = 1'b0;
    check_idle("mid_reset");
    fx = '{1}; fy = '{1};
    apply_stimulus(1'b1);
    check_output("post_mid_reset", 1);

    $display("[TB] counter saturation, 20 samples");
    fx = {}; fy = {};
    for (int i = 0; i < 20; i++) begin fx.push_back(1); fy.push_back(1); end
    apply_stimulus(1'b1);
    check_output("sat", 2);

    $display("[TB] extreme operands");
    fx = '{-32768, -32768, 32767}; fy = '{-32768, 32767, -32768};
    apply_stimulus(1'b1);
    check_output("extreme", 1);

    $display("[TB] random frames with gaps");
    gaps = 1'b1;
    for (int f = 0; f < 8; f++) begin
      fx = {}; fy = {};
      len = $urandom_range(1, 22);
      for (int i = 0; i < len; i++) begin
        fx.push_back(int'($signed(16'($urandom))));
        fy.push_back(int'($signed(16'($urandom))));
      end
      apply_stimulus(1'b1);
      check_output("rand", $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/leastsquares_accum.md
LEASTSQUARES_ACCUM -- requirements
Module: leastsquares_accum

Interface
REQ-001 Parameter DATA_W, default 16: width of signed sample operands x and y.
REQ-002 Parameter CNT_W, default 16: width of the sample counter res_n.
REQ-003 Parameter ACC_W, default 48: width of each signed sum output.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset.
REQ-005 Ports SHALL be, as name / direction / width / meaning:
- ACLK  in  1  clock.
- ARESET  in  1  synchronous active-high reset.
- s_valid  in  1  sample valid.
- s_ready  out  1  sample ready.
- s_x  in  DATA_W  signed x sample.
- s_y  in  DATA_W  signed y sample.
- s_last  in  1  final sample of the frame.
- res_valid  out  1  result valid.
- res_ready  in  1  result consumed.
- res_n  out  CNT_W  sample count.
- res_sx  out  ACC_W  sum of x.
- res_sy  out  ACC_W  sum of y.
- res_sxx  out  ACC_W  sum of x*x.
- res_sxy  out  ACC_W  sum of x*y.
- ovf  out  1  count saturated in this frame.
- busy  out  1  frame in progress (state not IDLE).

Function
REQ-006 States SHALL be IDLE, ACC, FLUSH and HOLD.
REQ-007 A sample SHALL be accepted on a cycle with s_valid=1 and s_ready=1.
REQ-008 s_ready SHALL be 1 in IDLE and ACC, and 0 in FLUSH and HOLD.
REQ-009 State transitions SHALL be:
- IDLE: accept without s_last -> ACC; accept with s_last -> FLUSH.
- ACC: accept with s_last -> FLUSH.
- FLUSH -> HOLD unconditionally after one cycle.
- HOLD: res_ready=1 -> IDLE.
REQ-010 Pipeline stage 1 SHALL register sign-extended x, y, x*x and x*y (full 2*DATA_W signed products) on the accepting edge.
REQ-011 Pipeline stage 2 SHALL add the stage-1 values into the accumulators on the next edge.
REQ-012 Accumulators SHALL sign-extend all operands to ACC_W and wrap modulo 2^ACC_W; no saturation.
REQ-013 res_n SHALL increment by one per accepted sample.
REQ-014 At 2^CNT_W-1, res_n SHALL hold its value and ovf SHALL be set; the sums SHALL continue to accumulate.
REQ-015 If s_last is accepted in cycle t, res_valid SHALL be 1 from cycle t+2, with all sums including that sample.
REQ-016 res_valid SHALL be 1 only in HOLD.
REQ-017 While res_valid=1 and res_ready=0, all res_* and ovf outputs SHALL remain stable.
REQ-018 On the res_valid and res_ready handshake, res_n, all sums and ovf SHALL be cleared to 0 at that edge, and s_ready SHALL be 1 from the next cycle.
REQ-019 res_ready outside HOLD SHALL be ignored.
REQ-020 s_x, s_y and s_last SHALL be ignored when s_ready=0 or s_valid=0.
REQ-021 Sample acceptance SHALL be lossless and back-to-back at one sample per cycle in IDLE and ACC.
REQ-022 Between frames, res_* outputs SHALL read 0; intermediate sums SHALL be visible on res_* only as an implementation side effect, and consumers SHALL qualify them with res_valid.

Reset
REQ-023 ARESET=1 at an edge SHALL force state IDLE and clear both pipeline stages, all accumulators, res_n and ovf, regardless of state.
REQ-024 During and after reset: res_valid=0, busy=0, all res_*=0, ovf=0, and s_ready=1 from the first cycle with ARESET=0.
REQ-025 Reset mid-frame SHALL discard partial sums; the next frame SHALL start from zero.

Verification
REQ-026 Frame (1,2),(2,4),(3,6), last on the third sample, back-to-back -> res_valid at t+2 with n=3, sx=6, sy=12, sxx=14, sxy=28, ovf=0.
REQ-027 Frame (-3,5),(-1,-2) -> n=2, sx=-4, sy=3, sxx=10, sxy=-13 (two's complement over ACC_W).
REQ-028 Single-sample frame (7,-7) with last -> FLUSH then HOLD; n=1, sx=7, sy=-7, sxx=49, sxy=-49.
REQ-029 Backpressure: after result, hold res_ready=0 for 5 cycles -> outputs stable and s_ready=0; then res_ready=1 -> outputs 0 and s_ready=1 next cycle; next frame (2,3) last -> n=1, sx=2, sxy=6.
REQ-030 Assert ARESET for one cycle after two samples (5,5),(5,5); then send (1,1) last -> n=1, sx=1, sxx=1.
REQ-031 With CNT_W=4, send 20 samples of (1,1) with last on the 20th -> n=15, ovf=1, sx=20, sxx=20; after handshake, ovf=0.
